// File: rtl/seq_mult_responder_pkg.sv
// rtl/seq_mult_responder_pkg.sv - shared state encodings and default width for the multiply unit
package seq_mult_responder_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mult_state_e;

endpackage

// File: rtl/seq_mult_responder.sv
// rtl/seq_mult_responder.sv - radix-2 shift-add multiply responder with request/response handshakes
module seq_mult_responder
   import seq_mult_responder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_signed,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_hi,
   output logic [WIDTH-1:0] resp_lo,
   output logic             busy
);

   localparam int              CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   mult_state_e          state_q;
   logic [CW-1:0]        count_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic                 neg_q;
   logic                 req_ready_q;
   logic                 resp_valid_q;
   logic                 busy_q;
   logic [WIDTH-1:0]     resp_hi_q;
   logic [WIDTH-1:0]     resp_lo_q;

   logic [WIDTH-1:0]     a_mag_d;
   logic [WIDTH-1:0]     b_mag_d;
   logic                 neg_d;
   logic [2*WIDTH-1:0]   acc_d;
   logic [2*WIDTH-1:0]   product_d;

   // MIN negates to itself, which read as unsigned is exactly the magnitude 2^(W-1).
   always_comb begin
      a_mag_d   = (req_signed && req_a[WIDTH-1]) ? (~req_a + WIDTH'(1)) : req_a;
      b_mag_d   = (req_signed && req_b[WIDTH-1]) ? (~req_b + WIDTH'(1)) : req_b;
      neg_d     = req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
      acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      product_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
   end

   // The multiplicand register is shifted one place per step instead of by count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         acc_q        <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         neg_q        <= 1'b0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         resp_hi_q    <= '0;
         resp_lo_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  mcand_q     <= {{WIDTH{1'b0}}, a_mag_d};
                  mplier_q    <= b_mag_d;
                  neg_q       <= neg_d;
                  acc_q       <= '0;
                  count_q     <= '0;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + CW'(1);
               if (count_q == LAST) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               resp_hi_q    <= product_d[2*WIDTH-1:WIDTH];
               resp_lo_q    <= product_d[WIDTH-1:0];
               busy_q       <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= ST_DONE;
            end
            ST_DONE: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign busy       = busy_q;
   assign resp_hi    = resp_hi_q;
   assign resp_lo    = resp_lo_q;

endmodule

// File: tb/tb_seq_mult_responder.sv
// tb/tb_seq_mult_responder.sv - directed vector bench for seq_mult_responder
module tb_seq_mult_responder;

   localparam int W       = 32;
   localparam int LATENCY = W + 1;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_signed;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic          resp_valid;
   logic          resp_ready;
   logic [W-1:0]  resp_hi;
   logic [W-1:0]  resp_lo;
   logic          busy;

   int checks = 0;
   int errors = 0;

   seq_mult_responder #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_signed (req_signed),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_hi    (resp_hi),
      .resp_lo    (resp_lo),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at #1 after a posedge with req_ready expected high; returns #1 after the accept edge.
   task automatic send_req(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_ready_before_accept", 64'(req_ready), 64'd1);
      req_signed = s;
      req_a      = a;
      req_b      = b;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      check("req_ready_drop_after_accept", 64'(req_ready), 64'd0);
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (!resp_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic finish_resp();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check("resp_valid_after_handshake", 64'(resp_valid), 64'd0);
      check("req_ready_after_handshake", 64'(req_ready), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_resp_hi"}, 64'(resp_hi), 64'd0);
      check({tag, "_resp_lo"}, 64'(resp_lo), 64'd0);
   endtask

   initial begin
      int lat;

      vecs[0] = '{1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F};
      vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6};
      vecs[2] = '{1'b0, 32'hFFFFFFF9, 32'd6,        32'h00000005, 32'hFFFFFFD6};
      vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[6] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      vecs[7] = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      vecs[8] = '{1'b1, 32'd5,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[9] = '{1'b0, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF};

      reset      = 1'b0;
      req_valid  = 1'b0;
      req_signed = 1'b0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         send_req(vecs[i].sgn, vecs[i].a, vecs[i].b);
         wait_resp(lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LATENCY));
         check($sformatf("vec%0d_hi", i), 64'(resp_hi), 64'(vecs[i].hi));
         check($sformatf("vec%0d_lo", i), 64'(resp_lo), 64'(vecs[i].lo));
         finish_resp();
      end

      // Backpressure: hold resp_ready low for 10 cycles in DONE.
      resp_ready = 1'b0;
      send_req(1'b0, 32'd7, 32'd9);
      wait_resp(lat);
      check("bp_latency", 64'(lat), 64'(LATENCY));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_resp_valid", 64'(resp_valid), 64'd1);
         check("bp_resp_lo", 64'(resp_lo), 64'd63);
         check("bp_resp_hi", 64'(resp_hi), 64'd0);
         check("bp_req_ready", 64'(req_ready), 64'd0);
      end
      finish_resp();

      // Operand changes and req_valid pulses while busy must be ignored.
      send_req(1'b0, 32'd11, 32'd13);
      repeat (3) @(posedge clk);
      #1;
      req_a     = 32'hFFFFFFFF;
      req_b     = 32'hFFFFFFFF;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("busy_req_ready_low", 64'(req_ready), 64'd0);
         check("busy_flag_high", 64'(busy), 64'd1);
      end
      req_valid = 1'b0;
      wait_resp(lat);
      check("ignore_latency", 64'(lat), 64'(LATENCY - 8));
      check("ignore_hi", 64'(resp_hi), 64'd0);
      check("ignore_lo", 64'(resp_lo), 64'd143);
      finish_resp();
      @(posedge clk); #1;
      check("no_second_accept_busy", 64'(busy), 64'd0);
      check("no_second_accept_ready", 64'(req_ready), 64'd1);

      // Asynchronous reset in BUSY at count 10.
      send_req(1'b0, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #2;
      check("pre_reset_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      send_req(1'b0, 32'd12, 32'd12);
      wait_resp(lat);
      check("post_reset_latency", 64'(lat), 64'(LATENCY));
      check("post_reset_hi", 64'(resp_hi), 64'd0);
      check("post_reset_lo", 64'(resp_lo), 64'd144);
      finish_resp();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
